// File: rtl/key_debounce_array.sv
// Multi-channel key conditioner: per-key 2-flop synchroniser, consecutive-sample
// debounce and a hold FSM emitting one-cycle press/release/long/repeat pulses.
module key_debounce_array #(
    parameter int KEY_NUM         = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter int REPEAT_EN       = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_value,
    output logic [KEY_NUM-1:0] press_flag,
    output logic [KEY_NUM-1:0] release_flag,
    output logic [KEY_NUM-1:0] long_flag,
    output logic [KEY_NUM-1:0] repeat_flag
);

    localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [DB_W-1:0]   DB_ZERO     = DB_W'(0);
    localparam logic [DB_W-1:0]   DB_ONE      = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO   = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic              IDLE_LVL    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic              RPT_ON      = (REPEAT_EN != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } hold_state_e;

    logic [KEY_NUM-1:0] s1_q, s1_d, s2_q, s2_d, raw_s;
    logic [KEY_NUM-1:0] key_value_q, key_value_d;
    logic [KEY_NUM-1:0] press_q, press_d, release_q, release_d;
    logic [KEY_NUM-1:0] long_q, long_d, repeat_q, repeat_d;
    logic [DB_W-1:0]    db_cnt_q   [KEY_NUM];
    logic [DB_W-1:0]    db_cnt_d   [KEY_NUM];
    logic [HOLD_W-1:0]  hold_cnt_q [KEY_NUM];
    logic [HOLD_W-1:0]  hold_cnt_d [KEY_NUM];
    hold_state_e        state_q    [KEY_NUM];
    hold_state_e        state_d    [KEY_NUM];

    // Normalise so that 1 always means pressed.
    assign raw_s = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;

    // Next-state logic: debounce commit first, then the hold FSM, so a release
    // commit overrides any long/repeat threshold reached on the same edge.
    always_comb begin
        s1_d        = key;
        s2_d        = s1_q;
        key_value_d = key_value_q;
        press_d     = {KEY_NUM{1'b0}};
        release_d   = {KEY_NUM{1'b0}};
        long_d      = {KEY_NUM{1'b0}};
        repeat_d    = {KEY_NUM{1'b0}};
        for (int i = 0; i < KEY_NUM; i++) begin
            db_cnt_d[i]   = db_cnt_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
            state_d[i]    = state_q[i];

            if (raw_s[i] == key_value_q[i]) begin
                db_cnt_d[i] = DB_ZERO;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i]    = DB_ZERO;
                key_value_d[i] = raw_s[i];
                press_d[i]     = raw_s[i];
                release_d[i]   = ~raw_s[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end

            if (release_d[i]) begin
                state_d[i]    = ST_IDLE;
                hold_cnt_d[i] = HOLD_ZERO;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        hold_cnt_d[i] = HOLD_ZERO;
                        if (press_d[i]) begin
                            state_d[i] = ST_HOLD;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt_q[i] == LONG_LAST) begin
                            long_d[i]     = 1'b1;
                            hold_cnt_d[i] = HOLD_ZERO;
                            state_d[i]    = ST_REPEAT;
                        end else begin
                            hold_cnt_d[i] = hold_cnt_q[i] + HOLD_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (hold_cnt_q[i] == REPEAT_LAST) begin
                            repeat_d[i]   = RPT_ON;
                            hold_cnt_d[i] = HOLD_ZERO;
                        end else begin
                            hold_cnt_d[i] = hold_cnt_q[i] + HOLD_ONE;
                        end
                    end
                    default: begin
                        state_d[i]    = ST_IDLE;
                        hold_cnt_d[i] = HOLD_ZERO;
                    end
                endcase
            end
        end
    end

    // State registers; reset parks the synchroniser at the idle pin level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_q        <= {KEY_NUM{IDLE_LVL}};
            s2_q        <= {KEY_NUM{IDLE_LVL}};
            key_value_q <= {KEY_NUM{1'b0}};
            press_q     <= {KEY_NUM{1'b0}};
            release_q   <= {KEY_NUM{1'b0}};
            long_q      <= {KEY_NUM{1'b0}};
            repeat_q    <= {KEY_NUM{1'b0}};
            for (int i = 0; i < KEY_NUM; i++) begin
                db_cnt_q[i]   <= DB_ZERO;
                hold_cnt_q[i] <= HOLD_ZERO;
                state_q[i]    <= ST_IDLE;
            end
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            key_value_q <= key_value_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            for (int i = 0; i < KEY_NUM; i++) begin
                db_cnt_q[i]   <= db_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                state_q[i]    <= state_d[i];
            end
        end
    end

    assign key_value    = key_value_q;
    assign press_flag   = press_q;
    assign release_flag = release_q;
    assign long_flag    = long_q;
    assign repeat_flag  = repeat_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench: two instances (auto-repeat on / off) driven with the same pins,
// sampled 1 time unit after each rising edge.
module tb_key_debounce_array;

    logic       clk     = 1'b0;
    logic       sys_rst = 1'b1;
    logic [1:0] key     = 2'b11;
    logic [1:0] kv, pf, rf, lf, rpf;
    logic [1:0] kv_n, pf_n, rf_n, lf_n, rpf_n;
    logic [1:0] seen_any, seen_any_n, seen_kv, seen_pf, seen_rep_n;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    key_debounce_array #(
        .KEY_NUM(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES(20), .REPEAT_CYCLES(5), .REPEAT_EN(1)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .key(key), .key_value(kv),
        .press_flag(pf), .release_flag(rf), .long_flag(lf), .repeat_flag(rpf)
    );

    key_debounce_array #(
        .KEY_NUM(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES(20), .REPEAT_CYCLES(5), .REPEAT_EN(0)
    ) dut_nr (
        .sys_clk(clk), .sys_rst(sys_rst), .key(key), .key_value(kv_n),
        .press_flag(pf_n), .release_flag(rf_n), .long_flag(lf_n), .repeat_flag(rpf_n)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            seen_any   = seen_any | pf | rf | lf | rpf;
            seen_any_n = seen_any_n | pf_n | rf_n | lf_n | rpf_n;
            seen_kv    = seen_kv | kv;
            seen_pf    = seen_pf | pf;
            seen_rep_n = seen_rep_n | rpf_n;
        end
    endtask

    task automatic clear_seen();
        seen_any   = 2'b00;
        seen_any_n = 2'b00;
        seen_kv    = 2'b00;
        seen_pf    = 2'b00;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        key     = 2'b11;
        clear_seen();
        step(3);
        n_checks++;
        if ({kv, pf, rf, lf, rpf} !== 10'b0) $display("FAIL reset_outputs: got %b want 0", {kv, pf, rf, lf, rpf});
        else n_pass++;
        n_checks++;
        if ({kv_n, pf_n, rf_n, lf_n, rpf_n} !== 10'b0) $display("FAIL reset_outputs_nr: got %b want 0", {kv_n, pf_n, rf_n, lf_n, rpf_n});
        else n_pass++;
        sys_rst = 1'b0;
        clear_seen();
        step(100);
        n_checks++;
        if ({seen_any, seen_any_n, seen_kv} !== 6'b0) $display("FAIL reset_quiet: got %b want 0", {seen_any, seen_any_n, seen_kv});
        else n_pass++;
    endtask

    task automatic test_press_release();
        clear_seen();
        key[0] = 1'b0;
        step(9);
        n_checks++;
        if ({seen_any, kv} !== 4'b0) $display("FAIL press_early: got %b want 0", {seen_any, kv});
        else n_pass++;
        step(1);
        n_checks++;
        if ({pf, kv} !== 4'b0101) $display("FAIL press_e9: got %b want 0101", {pf, kv});
        else n_pass++;
        step(1);
        n_checks++;
        if (pf !== 2'b00) $display("FAIL press_width: got %b want 00", pf);
        else n_pass++;
        step(29);
        key[0] = 1'b1;
        step(9);
        n_checks++;
        if ({rf, kv} !== 4'b0001) $display("FAIL release_early: got %b want 0001", {rf, kv});
        else n_pass++;
        step(1);
        n_checks++;
        if ({rf, kv, lf, rpf} !== 8'b01_00_00_00) $display("FAIL release_e49: got %b want 01000000", {rf, kv, lf, rpf});
        else n_pass++;
        n_checks++;
        if ({seen_any[1], seen_kv[1]} !== 2'b00) $display("FAIL ch1_silent: got %b want 00", {seen_any[1], seen_kv[1]});
        else n_pass++;
        clear_seen();
        step(20);
        n_checks++;
        if (seen_any !== 2'b00) $display("FAIL idle_after_release: got %b want 00", seen_any);
        else n_pass++;
    endtask

    task automatic test_bounce();
        clear_seen();
        key[0] = 1'b0;
        step(5);
        key[0] = 1'b1;
        step(2);
        key[0] = 1'b0;
        step(9);
        n_checks++;
        if ({seen_any, kv} !== 4'b0) $display("FAIL bounce_quiet: got %b want 0", {seen_any, kv});
        else n_pass++;
        step(1);
        n_checks++;
        if ({pf, kv} !== 4'b0101) $display("FAIL bounce_press: got %b want 0101", {pf, kv});
        else n_pass++;
        clear_seen();
        step(1);
        key[0] = 1'b1;
        step(10);
        n_checks++;
        if ({rf, seen_pf} !== 4'b0100) $display("FAIL bounce_single_press: got %b want 0100", {rf, seen_pf});
        else n_pass++;
    endtask

    task automatic test_long_repeat();
        seen_rep_n = 2'b00;
        clear_seen();
        key[0] = 1'b0;
        step(10);
        n_checks++;
        if (pf !== 2'b01) $display("FAIL lp_press: got %b want 01", pf);
        else n_pass++;
        step(19);
        n_checks++;
        if (lf !== 2'b00) $display("FAIL long_early: got %b want 00", lf);
        else n_pass++;
        step(1);
        n_checks++;
        if ({lf, lf_n} !== 4'b0101) $display("FAIL long_p20: got %b want 0101", {lf, lf_n});
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            step(4);
            n_checks++;
            if (rpf !== 2'b00) $display("FAIL repeat_early_%0d: got %b want 00", k, rpf);
            else n_pass++;
            step(1);
            n_checks++;
            if (rpf !== 2'b01) $display("FAIL repeat_%0d: got %b want 01", k, rpf);
            else n_pass++;
        end
        key[0] = 1'b1;
        step(5);
        n_checks++;
        if (rpf !== 2'b01) $display("FAIL repeat_4: got %b want 01", rpf);
        else n_pass++;
        step(5);
        n_checks++;
        if ({rf, rpf, rf_n} !== 6'b010001) $display("FAIL lp_release: got %b want 010001", {rf, rpf, rf_n});
        else n_pass++;
        clear_seen();
        step(30);
        n_checks++;
        if ({seen_any, seen_rep_n} !== 4'b0) $display("FAIL no_repeat_after: got %b want 0", {seen_any, seen_rep_n});
        else n_pass++;
    endtask

    task automatic test_collision();
        clear_seen();
        key[0] = 1'b0;
        step(10);
        n_checks++;
        if (pf !== 2'b01) $display("FAIL col_press: got %b want 01", pf);
        else n_pass++;
        step(10);
        key[0] = 1'b1;
        step(10);
        n_checks++;
        if ({rf, lf, kv} !== 6'b010000) $display("FAIL col_release_wins: got %b want 010000", {rf, lf, kv});
        else n_pass++;
        n_checks++;
        if ({rf_n, lf_n, kv_n} !== 6'b010000) $display("FAIL col_release_wins_nr: got %b want 010000", {rf_n, lf_n, kv_n});
        else n_pass++;
        clear_seen();
        step(30);
        n_checks++;
        if ({seen_any, seen_any_n} !== 4'b0) $display("FAIL col_quiet: got %b want 0", {seen_any, seen_any_n});
        else n_pass++;
    endtask

    task automatic test_independence_reset();
        clear_seen();
        key[0] = 1'b0;
        step(3);
        key[1] = 1'b0;
        step(7);
        n_checks++;
        if (pf !== 2'b01) $display("FAIL ind_press0: got %b want 01", pf);
        else n_pass++;
        step(3);
        n_checks++;
        if (pf !== 2'b10) $display("FAIL ind_press1: got %b want 10", pf);
        else n_pass++;
        step(5);
        sys_rst = 1'b1;
        step(2);
        n_checks++;
        if ({kv, rf, pf, lf, rpf} !== 10'b0) $display("FAIL midhold_reset: got %b want 0", {kv, rf, pf, lf, rpf});
        else n_pass++;
        sys_rst = 1'b0;
        clear_seen();
        step(9);
        n_checks++;
        if ({seen_any, seen_kv} !== 4'b0) $display("FAIL post_reset_quiet: got %b want 0", {seen_any, seen_kv});
        else n_pass++;
        step(1);
        n_checks++;
        if ({pf, kv, pf_n} !== 6'b111111) $display("FAIL repress: got %b want 111111", {pf, kv, pf_n});
        else n_pass++;
    endtask

    initial begin
        clear_seen();
        seen_rep_n = 2'b00;
        test_reset();
        test_press_release();
        test_bounce();
        test_long_repeat();
        test_collision();
        test_independence_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
